// File: rtl/maxpool_window_ctrl.sv
// Streaming 3x3 window scheduler for the max-pooling datapath: buffers two rows,
// issues stride-selected windows and reports frame completion after pipeline drain.
module maxpool_window_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WIDTH  = 256,
   parameter int PIPE_LAT   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          Start,
   input  logic [$clog2(MAX_WIDTH):0]    Cfg_Width,
   input  logic [15:0]                   Cfg_Height,
   input  logic [1:0]                    Cfg_Stride,
   input  logic [DATA_WIDTH-1:0]         In_Data,
   input  logic                          In_Valid,
   output logic                          In_Ready,
   output logic [DATA_WIDTH-1:0]         Win0,
   output logic [DATA_WIDTH-1:0]         Win1,
   output logic [DATA_WIDTH-1:0]         Win2,
   output logic [DATA_WIDTH-1:0]         Win3,
   output logic [DATA_WIDTH-1:0]         Win4,
   output logic [DATA_WIDTH-1:0]         Win5,
   output logic [DATA_WIDTH-1:0]         Win6,
   output logic [DATA_WIDTH-1:0]         Win7,
   output logic [DATA_WIDTH-1:0]         Win8,
   output logic                          Win_Valid,
   output logic                          Busy,
   output logic                          Frame_Done,
   output logic                          Cfg_Err
);

   localparam int CW = $clog2(MAX_WIDTH) + 1;
   localparam int AW = $clog2(MAX_WIDTH);
   localparam int LW = $clog2(PIPE_LAT + 1) + 1;
   localparam logic [CW-1:0] MAX_W = CW'(MAX_WIDTH);
   localparam logic [LW-1:0] LAT   = LW'(PIPE_LAT);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                          state;
   logic [CW-1:0]                   w_r, col;
   logic [15:0]                     h_r, row;
   logic [1:0]                      s_r, col_ph, row_ph;
   logic [1:0]                      col_ph_nxt, row_ph_nxt;
   logic [LW-1:0]                   since_win;
   logic [8:0][DATA_WIDTH-1:0]      win, win_nxt, win_out;
   logic [DATA_WIDTH-1:0]           lb0 [MAX_WIDTH];
   logic [DATA_WIDTH-1:0]           lb1 [MAX_WIDTH];
   logic [AW-1:0]                   addr;
   logic                            accept, issue, last_col, last_row, cfg_bad;

   assign addr     = col[AW-1:0];
   assign accept   = In_Valid && In_Ready;
   assign last_col = (col == w_r - CW'(1));
   assign last_row = (row == h_r - 16'd1);
   assign issue    = accept && (row >= 16'd2) && (col >= CW'(2)) &&
                     (col_ph == 2'd0) && (row_ph == 2'd0);
   assign cfg_bad  = (Cfg_Width < CW'(3)) || (Cfg_Width > MAX_W) ||
                     (Cfg_Height < 16'd3) || (Cfg_Stride == 2'd0);

   // New right column comes from the two line buffers (older rows) and the live pixel.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_nxt[3*r]   = win[3*r+1];
         win_nxt[3*r+1] = win[3*r+2];
      end
      win_nxt[2] = lb1[addr];
      win_nxt[5] = lb0[addr];
      win_nxt[8] = In_Data;
   end

   // Phases are pinned to 0 until the first full-window column/row is reached.
   always_comb begin
      // NOTE: assign every always_comb output a default first so no path infers a latch.
      col_ph_nxt = 2'd0;
      row_ph_nxt = 2'd0;
      if (!last_col && col >= CW'(2))
         col_ph_nxt = (col_ph == s_r - 2'd1) ? 2'd0 : col_ph + 2'd1;
      if (row >= 16'd2)
         row_ph_nxt = (row_ph == s_r - 2'd1) ? 2'd0 : row_ph + 2'd1;
   end

   // NOTE: line buffers carry no reset; their contents are always overwritten before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[addr] <= lb0[addr];
         lb0[addr] <= In_Data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         w_r        <= '0;
         h_r        <= '0;
         s_r        <= '0;
         col        <= '0;
         row        <= '0;
         col_ph     <= '0;
         row_ph     <= '0;
         since_win  <= '0;
         win        <= '0;
         win_out    <= '0;
         In_Ready   <= 1'b0;
         Win_Valid  <= 1'b0;
         Busy       <= 1'b0;
         Frame_Done <= 1'b0;
         Cfg_Err    <= 1'b0;
      end else begin
         Win_Valid  <= 1'b0;
         Frame_Done <= 1'b0;
         Cfg_Err    <= 1'b0;
         if (issue)
            since_win <= '0;
         else if (since_win != LAT)
            since_win <= since_win + LW'(1);

         case (state)
            IDLE: begin
               if (Start) begin
                  if (cfg_bad) begin
                     Cfg_Err <= 1'b1;
                  end else begin
                     w_r       <= Cfg_Width;
                     h_r       <= Cfg_Height;
                     s_r       <= Cfg_Stride;
                     col       <= '0;
                     row       <= '0;
                     col_ph    <= '0;
                     row_ph    <= '0;
                     since_win <= '0;
                     In_Ready  <= 1'b1;
                     Busy      <= 1'b1;
                     state     <= RUN;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  win <= win_nxt;
                  if (issue) begin
                     win_out   <= win_nxt;
                     Win_Valid <= 1'b1;
                  end
                  if (last_col) begin
                     col    <= '0;
                     col_ph <= 2'd0;
                     row    <= row + 16'd1;
                     row_ph <= row_ph_nxt;
                     if (last_row) begin
                        In_Ready <= 1'b0;
                        state    <= DRAIN;
                     end
                  end else begin
                     col    <= col + CW'(1);
                     col_ph <= col_ph_nxt;
                  end
               end
            end
            DRAIN: begin
               // Last window left PIPE_LAT cycles ago; done pulses one cycle later.
               if (since_win == LAT) begin
                  Frame_Done <= 1'b1;
                  Busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Win0 = win_out[0];
   assign Win1 = win_out[1];
   assign Win2 = win_out[2];
   assign Win3 = win_out[3];
   assign Win4 = win_out[4];
   assign Win5 = win_out[5];
   assign Win6 = win_out[6];
   assign Win7 = win_out[7];
   assign Win8 = win_out[8];

endmodule
